apb2ahb_bridge: RTL and testbench

- APB responder that forwards each APB transfer as one single AHB-Lite transfer; the bridge is the AHB master.
- Covers the opposite direction of the AHB-to-APB path, so an APB-only agent can reach AHB memory.
- One clock: the APB side and the AHB side both run on HCLK.
- Exactly one transfer is outstanding at a time. APB wait states (PREADY) cover the whole AHB round trip.

---
 rtl/ahb_apb_pkg.sv | 11 +
 rtl/apb2ahb_bridge.sv | 87 ++++++++
 tb/tb_apb2ahb_bridge.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared AHB-Lite encodings and the APB-to-AHB bridge state type
package ahb_apb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} bridge_state_t;
endpackage

// File: rtl/apb2ahb_bridge.sv
// apb2ahb_bridge: APB responder forwarding each transfer as one single AHB-Lite word transfer
module apb2ahb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int             AW          = 32,
    parameter int             DW          = 32,
    parameter logic [AW-1:0]  ADDR_OFFSET = '0
) (
    input  logic          HCLK,
    input  logic          HRST,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [AW-1:0] PADDR,
    input  logic [DW-1:0] PWDATA,
    output logic [DW-1:0] PRDATA,
    output logic          PREADY,
    output logic          PSLVERR,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic [DW-1:0] HRDATA,
    input  logic          HREADY,
    input  logic          HRESP
);
    bridge_state_t state, state_n;
    logic          capture;
    logic          abort;
    logic          drop;

    assign HSIZE = HSIZE_WORD;
    assign drop  = abort || !PSEL;

    // state register; reset forces IDLE at once
    always_ff @(posedge HCLK or negedge HRST) begin
        if (!HRST) state <= ST_IDLE;
        else       state <= state_n;
    end

    // next state: accept setup only in IDLE, finish AHB phases even when APB has gone away
    always_comb begin
        state_n = state;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                capture = PSEL && !PENABLE;
                state_n = capture ? ST_ADDR : ST_IDLE;
            end
            ST_ADDR: state_n = HREADY ? ST_DATA : ST_ADDR;
            ST_DATA: state_n = !HREADY ? ST_DATA : drop ? ST_IDLE : ST_RESP;
            default: state_n = ST_IDLE;
        endcase
    end

    // registered AHB request, APB response and the sticky PSEL-dropped flag
    always_ff @(posedge HCLK or negedge HRST) begin
        if (!HRST) begin
            HADDR   <= '0;
            HWRITE  <= 1'b0;
            HWDATA  <= '0;
            HTRANS  <= HTRANS_IDLE;
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            abort   <= 1'b0;
        end else begin
            if (capture) begin
                HADDR  <= PADDR + ADDR_OFFSET;
                HWRITE <= PWRITE;
                HWDATA <= PWDATA;
                abort  <= 1'b0;
            end
            if (state == ST_ADDR || state == ST_DATA) abort <= drop;
            HTRANS <= (state_n == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            PREADY <= (state_n == ST_RESP);
            if (state == ST_DATA && state_n == ST_RESP) begin
                if (!HWRITE) PRDATA <= HRDATA;
                PSLVERR <= (HRESP == HRESP_ERROR);
            end else if (state == ST_RESP) begin
                PRDATA  <= '0;
                PSLVERR <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_apb2ahb_bridge.sv
// tb_apb2ahb_bridge: directed and random APB transfers checked against a cycle-count model
module tb_apb2ahb_bridge;
    localparam logic [31:0] OFF  = 32'h1000_0000;
    localparam logic [31:0] WOFF = 32'h0000_0008;

    logic        HCLK = 1'b0;
    logic        HRST = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0, HRDATA = '0;
    logic        HREADY = 1'b1, HRESP = 1'b0;
    logic [31:0] PRDATA, HADDR, HWDATA, w_PRDATA, w_HADDR, w_HWDATA;
    logic        PREADY, PSLVERR, HWRITE, w_PREADY, w_PSLVERR, w_HWRITE;
    logic [1:0]  HTRANS, w_HTRANS;
    logic [2:0]  HSIZE, w_HSIZE;
    int          total = 0;
    int          bad = 0;

    always #5 HCLK = ~HCLK;

    apb2ahb_bridge #(.AW(32), .DW(32), .ADDR_OFFSET(OFF)) dut (
        .HCLK(HCLK), .HRST(HRST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    apb2ahb_bridge #(.AW(32), .DW(32), .ADDR_OFFSET(WOFF)) dut_wrap (
        .HCLK(HCLK), .HRST(HRST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(w_PRDATA), .PREADY(w_PREADY), .PSLVERR(w_PSLVERR),
        .HADDR(w_HADDR), .HTRANS(w_HTRANS), .HWRITE(w_HWRITE), .HSIZE(w_HSIZE), .HWDATA(w_HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_htrans"}, {30'd0, HTRANS}, 32'd0);
        chk({tag, "_pready"}, {31'd0, PREADY}, 32'd0);
        chk({tag, "_pslverr"}, {31'd0, PSLVERR}, 32'd0);
        chk({tag, "_prdata"}, PRDATA, 32'd0);
    endtask

    // one APB transfer: aw address-phase and dw data-phase wait states, PREADY due in cycle 3+aw+dw
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int aw, input int dw, input bit err, input bit b2b);
        int  last = 3 + aw + dw;
        bit  in_addr, in_data;
        for (int c = 0; c <= last; c++) begin
            in_addr = (c >= 1) && (c <= 1 + aw);
            in_data = (c > 1 + aw) && (c < last);
            if (c == 0) begin
                PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = wd;
            end else if (c == last && b2b) begin
                PENABLE = 1'b0; PADDR = $urandom; PWDATA = $urandom;
            end else begin
                PENABLE = 1'b1;
            end
            HREADY = in_addr ? (c == 1 + aw) : in_data ? (c == last - 1) : 1'b1;
            HRESP  = err && in_data && (c >= last - 2);
            HRDATA = (in_data && c == last - 1) ? rd : $urandom;
            @(negedge HCLK);
            if (c == 0) chk_idle("setup");
            chk("htrans", {30'd0, HTRANS}, in_addr ? 32'd2 : 32'd0);
            chk("pready", {31'd0, PREADY}, {31'd0, c == last});
            chk("hsize", {29'd0, HSIZE}, 32'd2);
            if (in_addr) begin
                chk("haddr", HADDR, a + OFF);
                chk("haddr_wrap", w_HADDR, a + WOFF);
                chk("hwrite", {31'd0, HWRITE}, {31'd0, w});
            end
            if (in_data && w) chk("hwdata", HWDATA, wd);
            chk("prdata", PRDATA, (c == last && !w) ? rd : 32'd0);
            chk("pslverr", {31'd0, PSLVERR}, {31'd0, c == last && err});
            step();
        end
        if (!b2b) begin
            PSEL = 1'b0; PENABLE = 1'b0;
        end
    endtask

    initial begin
        #1;
        step();
        @(negedge HCLK);
        chk_idle("reset");
        chk("reset_haddr", HADDR, 32'd0);
        chk("reset_hwdata", HWDATA, 32'd0);
        chk("reset_hwrite", {31'd0, HWRITE}, 32'd0);
        HRST = 1'b1;
        step();

        xfer(1'b1, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 1'b0);
        xfer(1'b0, 32'h200, 32'h0, 32'h1234_5678, 0, 3, 1'b0, 1'b0);
        xfer(1'b1, 32'h300, 32'hA5A5_5A5A, 32'h0, 2, 0, 1'b0, 1'b0);
        xfer(1'b0, 32'h400, 32'h0, 32'hBAD0_BAD0, 0, 1, 1'b1, 1'b1);
        xfer(1'b0, 32'h404, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0, 1'b1);
        xfer(1'b0, 32'hFFFF_FFFC, 32'h0, 32'h5555_AAAA, 1, 1, 1'b0, 1'b0);
        chk("wrap_haddr_hold", w_HADDR, 32'h0000_0004);

        // PENABLE without setup is ignored
        PSEL = 1'b1; PENABLE = 1'b1;
        step();
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge HCLK);
        chk_idle("penable_only");
        step();

        // PSEL dropped during an address phase: AHB completes, no PREADY, no latching
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h500;
        step();
        PSEL = 1'b0;
        HRESP = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            HREADY = (c != 1);
            HRDATA = $urandom;
            @(negedge HCLK);
            chk("abort_htrans", {30'd0, HTRANS}, (c <= 2) ? 32'd2 : 32'd0);
            chk("abort_pready", {31'd0, PREADY}, 32'd0);
            chk("abort_prdata", PRDATA, 32'd0);
            chk("abort_pslverr", {31'd0, PSLVERR}, 32'd0);
            step();
        end
        HRESP = 1'b0;
        xfer(1'b1, 32'h504, 32'h1111_2222, 32'h0, 0, 0, 1'b0, 1'b0);

        // reset while the data phase is stalled
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h600; PWDATA = 32'hCAFE_F00D; HREADY = 1'b1;
        step();
        PENABLE = 1'b1;
        step();
        HREADY = 1'b0;
        @(negedge HCLK);
        chk("pre_rst_hwdata", HWDATA, 32'hCAFE_F00D);
        @(posedge HCLK);
        #2;
        HRST = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_haddr", HADDR, 32'd0);
        chk("async_rst_hwdata", HWDATA, 32'd0);
        chk("async_rst_hwrite", {31'd0, HWRITE}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
        @(negedge HCLK);
        HRST = 1'b1;
        step();
        xfer(1'b0, 32'h604, 32'h0, 32'h7777_8888, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int  aw = $urandom_range(0, 3);
            int  dw = $urandom_range(0, 3);
            bit  er = (dw > 0) && ($urandom_range(0, 2) == 0);
            xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, aw, dw, er, 1'($urandom_range(0, 1)));
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge HCLK);
        chk_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
